// File: rtl/load_store_unit_if.sv
// Bundle of core request/response and data-memory signals for the load/store unit.
// The slave modport is the unit's view. The master modport is the core plus memory side.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    modport slave (
        input  req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready, mem_rd,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wd, mem_we
    );

    modport master (
        output req_valid, req_store, req_funct3, req_addr, req_wdata, resp_ready, mem_rd,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_addr, mem_wd, mem_we
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/halfword/word core requests into word accesses on a
// single-port data memory. Sub-word stores use read-modify-write.
module load_store_unit #(
    parameter int unsigned MEM_WORDS = 1024
) (
    input logic             clk,
    input logic             rst,
    load_store_unit_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, RESP} state_e;

    localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

    state_e      state_q, state_d;
    logic        store_q, store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] merge_q, merge_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        req_illegal, req_misaligned, req_out_of_range, req_err;
    logic [4:0]  byte_shift, half_shift;
    logic [31:0] rd_shifted;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] load_data;
    logic [31:0] merged;

    // Checks are applied to the live request bus because they decide the state taken on accept.
    always_comb begin
        req_illegal = bus.req_store ? !(bus.req_funct3 inside {3'b000, 3'b001, 3'b010})
                                    : (bus.req_funct3 inside {3'b011, 3'b110, 3'b111});
        req_misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0])
                      || ((bus.req_funct3 == 3'b010) && (bus.req_addr[1:0] != 2'b00));
        req_out_of_range = bus.req_addr[31:2] >= WORD_LIMIT;
        req_err = req_illegal || req_misaligned || req_out_of_range;
    end

    always_comb begin
        byte_shift = {addr_q[1:0], 3'b000};
        half_shift = {addr_q[1], 4'b0000};
        rd_shifted = bus.mem_rd >> byte_shift;
        rd_byte    = rd_shifted[7:0];
        rd_half    = addr_q[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];

        case (funct3_q)
            3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  load_data = {24'h0, rd_byte};
            3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
            3'b101:  load_data = {16'h0, rd_half};
            default: load_data = bus.mem_rd;
        endcase

        if (funct3_q[1:0] == 2'b00) begin
            merged = (bus.mem_rd & ~(32'h0000_00FF << byte_shift))
                   | ({24'h0, wdata_q[7:0]} << byte_shift);
        end else begin
            merged = (bus.mem_rd & ~(32'h0000_FFFF << half_shift))
                   | ({16'h0, wdata_q[15:0]} << half_shift);
        end
    end

    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d  = state_q;
        store_d  = store_q;
        funct3_d = funct3_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        merge_d  = merge_q;
        rdata_d  = rdata_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    store_d  = bus.req_store;
                    funct3_d = bus.req_funct3;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    rdata_d  = 32'h0;
                    err_d    = req_err;
                    if (req_err) begin
                        state_d = RESP;
                    end else if (!bus.req_store) begin
                        state_d = LOAD;
                    end else if (bus.req_funct3 == 3'b010) begin
                        merge_d = bus.req_wdata;
                        state_d = WRITE;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            LOAD: begin
                rdata_d = load_data;
                state_d = RESP;
            end
            RMW_RD: begin
                merge_d = merged;
                state_d = WRITE;
            end
            WRITE: state_d = RESP;
            RESP: begin
                if (bus.resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Memory-facing outputs are gated by rst so a reset landing on WRITE can never commit.
    always_comb begin
        bus.req_ready  = (state_q == IDLE) && !rst;
        bus.resp_valid = (state_q == RESP) && !rst;
        bus.resp_rdata = rdata_q;
        bus.resp_err   = err_q;
        bus.mem_we     = (state_q == WRITE) && !rst;
        bus.mem_wd     = bus.mem_we ? merge_q : 32'h0;
        bus.mem_addr   = ((state_q inside {LOAD, RMW_RD, WRITE}) && !rst)
                       ? {2'b00, addr_q[31:2]} : 32'h0;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            store_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            merge_q  <= 32'h0;
            rdata_q  <= 32'h0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            store_q  <= store_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            merge_q  <= merge_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit. It uses a behavioural word memory and
// hand-computed expected values.
module tb_load_store_unit;
    localparam int unsigned MEM_WORDS = 1024;

    logic clk;
    logic rst;
    int   passed;
    int   total;
    int   we_total;
    logic [31:0] last_wa;
    logic [31:0] last_wd;
    logic [31:0] mem [MEM_WORDS];

    load_store_unit_if bus ();

    load_store_unit #(.MEM_WORDS(MEM_WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign bus.mem_rd = (bus.mem_addr < MEM_WORDS) ? mem[bus.mem_addr[9:0]] : 32'h0;

    always @(posedge clk) begin
        if (bus.mem_we) begin
            mem[bus.mem_addr[9:0]] <= bus.mem_wd;
            we_total = we_total + 1;
            last_wa  = bus.mem_addr;
            last_wd  = bus.mem_wd;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Issues one request, measures accept-to-response latency, captures the response and completes the handshake.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output int lat, output logic [31:0] rdata,
                         output logic err, output int writes);
        int we_start;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        @(posedge clk);
        we_start = we_total;
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.req_addr  = 32'hFFFF_FFFF;
        bus.req_wdata = 32'h0;
        lat = 1;
        while (!bus.resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rdata  = bus.resp_rdata;
        err    = bus.resp_err;
        writes = we_total - we_start;
        @(posedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++; if (bus.req_ready !== 1'b0) $display("FAIL reset_req_ready: got %b exp 0", bus.req_ready); else passed++;
        total++; if (bus.resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b exp 0", bus.resp_valid); else passed++;
        total++; if (bus.mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b exp 0", bus.mem_we); else passed++;
        total++; if ({bus.mem_addr, bus.mem_wd} !== 64'h0) $display("FAIL reset_mem_bus: got %h/%h exp 0/0", bus.mem_addr, bus.mem_wd); else passed++;
        total++; if ({bus.resp_rdata, bus.resp_err} !== 33'h0) $display("FAIL reset_resp: got %h/%b exp 0/0", bus.resp_rdata, bus.resp_err); else passed++;
        rst = 1'b0;
        @(negedge clk);
        total++; if (bus.req_ready !== 1'b1) $display("FAIL idle_req_ready: got %b exp 1", bus.req_ready); else passed++;
    endtask

    task automatic test_loads;
        logic [2:0]  f3   [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b010};
        logic [31:0] addr [6] = '{32'h15, 32'h15, 32'h16, 32'h14, 32'h14, 32'hFFC};
        logic [31:0] exp  [6] = '{32'hFFFF_FFAA, 32'h0000_00AA, 32'hFFFF_8899,
                                  32'h0000_AABB, 32'h8899_AABB, 32'h0BAD_F00D};
        int lat, writes;
        logic [31:0] rdata;
        logic err;
        for (int i = 0; i < 6; i++) begin
            issue(1'b0, f3[i], addr[i], 32'h0, lat, rdata, err, writes);
            total++; if (rdata !== exp[i]) $display("FAIL load_data[%0d]: got %h exp %h", i, rdata, exp[i]); else passed++;
            total++; if ({err, writes, lat} !== {1'b0, 32'd0, 32'd2}) $display("FAIL load_ctrl[%0d]: err %b writes %0d lat %0d exp 0/0/2", i, err, writes, lat); else passed++;
        end
    endtask

    task automatic test_stores;
        int lat, writes;
        logic [31:0] rdata;
        logic err;
        issue(1'b1, 3'b000, 32'h0E, 32'hDEAD_BEEF, lat, rdata, err, writes);
        total++; if ({writes, lat} !== {32'd1, 32'd3}) $display("FAIL sb_ctrl: writes %0d lat %0d exp 1/3", writes, lat); else passed++;
        total++; if ({last_wa, last_wd} !== {32'd3, 32'h11EF_3344}) $display("FAIL sb_write: got %h/%h exp 3/11ef3344", last_wa, last_wd); else passed++;
        total++; if ({rdata, err} !== 33'h0) $display("FAIL sb_resp: got %h/%b exp 0/0", rdata, err); else passed++;
        issue(1'b0, 3'b010, 32'h0C, 32'h0, lat, rdata, err, writes);
        total++; if (rdata !== 32'h11EF_3344) $display("FAIL sb_readback: got %h exp 11ef3344", rdata); else passed++;

        issue(1'b1, 3'b001, 32'h1A, 32'h1234_5678, lat, rdata, err, writes);
        total++; if ({writes, lat} !== {32'd1, 32'd3}) $display("FAIL sh_ctrl: writes %0d lat %0d exp 1/3", writes, lat); else passed++;
        total++; if (mem[6] !== 32'h5678_F00D) $display("FAIL sh_mem: got %h exp 5678f00d", mem[6]); else passed++;

        issue(1'b1, 3'b010, 32'h20, 32'hA5A5_5A5A, lat, rdata, err, writes);
        total++; if ({writes, lat} !== {32'd1, 32'd2}) $display("FAIL sw_ctrl: writes %0d lat %0d exp 1/2", writes, lat); else passed++;
        total++; if (mem[8] !== 32'hA5A5_5A5A) $display("FAIL sw_mem: got %h exp a5a55a5a", mem[8]); else passed++;
    endtask

    task automatic test_errors;
        logic        st   [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [2:0]  f3   [5] = '{3'b010, 3'b001, 3'b010, 3'b011, 3'b100};
        logic [31:0] addr [5] = '{32'h02, 32'h01, 32'h1000, 32'h14, 32'h14};
        int lat, writes;
        logic [31:0] rdata;
        logic err;
        for (int i = 0; i < 5; i++) begin
            issue(st[i], f3[i], addr[i], 32'hFFFF_FFFF, lat, rdata, err, writes);
            total++; if ({err, rdata} !== {1'b1, 32'h0}) $display("FAIL err_resp[%0d]: err %b rdata %h exp 1/0", i, err, rdata); else passed++;
            total++; if ({writes, lat} !== {32'd0, 32'd1}) $display("FAIL err_ctrl[%0d]: writes %0d lat %0d exp 0/1", i, writes, lat); else passed++;
        end
        total++; if (mem[5] !== 32'h8899_AABB) $display("FAIL err_mem: got %h exp 8899aabb", mem[5]); else passed++;
    endtask

    task automatic test_backpressure;
        int lat;
        logic [31:0] held;
        logic stable_ok;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'b010;
        bus.req_addr   = 32'h14;
        @(posedge clk);
        @(negedge clk);
        bus.req_funct3 = 3'b100;
        bus.req_addr   = 32'h15;
        lat = 1;
        while (!bus.resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        held = bus.resp_rdata;
        total++; if ({lat, held} !== {32'd2, 32'h8899_AABB}) $display("FAIL bp_first: lat %0d rdata %h exp 2/8899aabb", lat, held); else passed++;
        stable_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== held || bus.req_ready !== 1'b0) stable_ok = 1'b0;
            @(negedge clk);
        end
        total++; if (stable_ok !== 1'b1) $display("FAIL bp_stable: got %b exp 1", stable_ok); else passed++;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        total++; if ({bus.resp_valid, bus.req_ready} !== 2'b01) $display("FAIL bp_release: valid/ready %b%b exp 01", bus.resp_valid, bus.req_ready); else passed++;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        total++; if ({lat, bus.resp_rdata} !== {32'd2, 32'h0000_00AA}) $display("FAIL bp_second: lat %0d rdata %h exp 2/000000aa", lat, bus.resp_rdata); else passed++;
        @(posedge clk);
    endtask

    task automatic test_back_to_back;
        int acc;
        logic [2:0] f3 [2] = '{3'b010, 3'b011};
        int exp [2] = '{4, 6};
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.req_valid  = 1'b1;
            bus.req_store  = 1'b0;
            bus.req_funct3 = f3[k];
            bus.req_addr   = 32'h14;
            acc = 0;
            for (int i = 0; i < 12; i++) begin
                if (bus.req_ready) acc++;
                @(negedge clk);
            end
            bus.req_valid = 1'b0;
            total++; if (acc !== exp[k]) $display("FAIL b2b_accepts[%0d]: got %0d exp %0d", k, acc, exp[k]); else passed++;
        end
    endtask

    task automatic test_reset_mid_write;
        int we_start;
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_store  = 1'b1;
        bus.req_funct3 = 3'b001;
        bus.req_addr   = 32'h1A;
        bus.req_wdata  = 32'h0000_FFFF;
        @(posedge clk);
        we_start = we_total;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (bus.mem_we !== 1'b0) $display("FAIL rst_write_we: got %b exp 0", bus.mem_we); else passed++;
        @(negedge clk);
        total++; if ({bus.resp_valid, bus.req_ready, bus.mem_we, bus.resp_err} !== 4'b0000) $display("FAIL rst_outputs: valid/ready/we/err %b%b%b%b exp 0000", bus.resp_valid, bus.req_ready, bus.mem_we, bus.resp_err); else passed++;
        rst = 1'b0;
        @(negedge clk);
        total++; if ({bus.req_ready, bus.resp_valid, bus.mem_addr, bus.mem_wd, bus.resp_rdata} !== {2'b10, 96'h0}) $display("FAIL rst_idle: ready %b valid %b addr %h wd %h rdata %h", bus.req_ready, bus.resp_valid, bus.mem_addr, bus.mem_wd, bus.resp_rdata); else passed++;
        total++; if ({we_total - we_start, mem[6]} !== {32'd0, 32'h5678_F00D}) $display("FAIL rst_no_write: writes %0d mem %h exp 0/5678f00d", we_total - we_start, mem[6]); else passed++;
    endtask

    initial begin
        passed   = 0;
        total    = 0;
        we_total = 0;
        last_wa  = 32'h0;
        last_wd  = 32'h0;
        for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'h0;
        mem[3]    = 32'h1122_3344;
        mem[5]    = 32'h8899_AABB;
        mem[6]    = 32'hCAFE_F00D;
        mem[1023] = 32'h0BAD_F00D;
        bus.req_valid  = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        bus.resp_ready = 1'b1;

        test_reset();
        test_loads();
        test_stores();
        test_errors();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_write();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
